// File: rtl/miner_pkg.sv
// Shared mining definitions: header-block padding, default pipeline latency,
// nonce/hash types, the scanner state encoding and the target comparison.
package miner_pkg;

  typedef logic [31:0]  nonce_t;
  typedef logic [255:0] hash_t;

  // Clocks from data1 to hash2 through sha256_double.
  localparam int PIPE_LAT_DEFAULT = 129;

  // Fixed upper part of the second 512-bit header block: SHA-256 length word
  // (640 bits = 0x280) at the top, zero fill, and the 0x80 pad marker just
  // above the nonce.
  localparam logic [383:0] DATA1_PAD = {32'h0000_0280, 320'h0, 32'h8000_0000};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

  // A hash wins when, read as an unsigned big-endian number, it does not
  // exceed the target.
  function automatic logic hash_meets_target(input hash_t h, input hash_t t);
    return (h <= t);
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// Small synchronous FIFO for winning nonces. DEPTH must be a power of two
// (>= 2). Pushes into a full FIFO are refused unless a pop happens in the
// same cycle; stored entries are never overwritten. The head is read straight
// from the storage so it is valid in the same cycle found_valid is.
module hit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Next storage and pointer values.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage and pointer registers; reset empties and zeroes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/nonce_scanner.sv
// Work-unit sequencer around sha256_double. Takes one job, issues one nonce
// per clock on data1, tracks in-flight nonces with a PIPE_LAT-deep valid
// shift register, compares each returning hash2 against the target and
// queues winners in hit_fifo.
// Optional build macro NONCE_SCANNER_DROP_CNT_EN adds the drop_cnt output
// (saturating count of hits lost to a full FIFO, cleared on job accept).
module nonce_scanner
  import miner_pkg::*;
#(
  parameter int PIPE_LAT  = PIPE_LAT_DEFAULT,
  parameter int HIT_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          work_valid,
  output logic          work_ready,
  input  logic [255:0]  work_midstate,
  input  logic [95:0]   work_tail,
  input  logic [255:0]  work_target,
  input  logic [31:0]   work_nonce_start,
  input  logic [31:0]   work_nonce_end,
  input  logic          abort,
  output logic [255:0]  hash0,
  output logic [511:0]  data1,
  input  logic [255:0]  hash2,
  output logic          found_valid,
  input  logic          found_ready,
  output logic [31:0]   found_nonce,
  output logic          busy,
  output logic          done
`ifdef NONCE_SCANNER_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  scan_state_e         state_q, state_d;
  hash_t               midstate_q, midstate_d;
  logic [95:0]         tail_q, tail_d;
  hash_t               target_q, target_d;
  nonce_t              end_q, end_d;
  nonce_t              issue_q, issue_d;
  nonce_t              result_q, result_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [PIPE_LAT-1:0] vld_shift;
  logic                done_q, done_d;

  logic                handshake;
  logic                abort_fire;
  logic                result_valid;
  logic                hit;
  logic                hit_accept;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop_fire;

  assign handshake  = work_valid && (state_q == ST_IDLE);
  // Abort only means something while a job is running; in IDLE it is ignored,
  // which also covers an abort coinciding with the job handshake.
  assign abort_fire = abort && (state_q != ST_IDLE);

  // In-flight tracker: a 1 enters for every nonce issued in SCAN, 0 otherwise,
  // and reaches the top bit exactly when that nonce's hash2 arrives.
  assign vld_shift[0] = (state_q == ST_SCAN);
  generate
    for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_vld_shift
      assign vld_shift[gi] = vld_q[gi-1];
    end
  endgenerate

  // Result path: compare the arriving hash, suppressed in an abort cycle so
  // nothing is written to the FIFO once the job is cancelled.
  assign result_valid = vld_q[PIPE_LAT-1] && !abort_fire;
  assign hit          = result_valid && hash_meets_target(hash2, target_q);
  assign pop_fire     = found_ready && !fifo_empty;
  // A full FIFO still takes a hit if the consumer pops in the same cycle.
  assign hit_accept   = hit && (!fifo_full || pop_fire);

  // Next-state, job latch, nonce counters and in-flight register.
  always_comb begin
    state_d    = state_q;
    midstate_d = midstate_q;
    tail_d     = tail_q;
    target_d   = target_q;
    end_d      = end_q;
    issue_d    = issue_q;
    result_d   = result_valid ? (result_q + 32'd1) : result_q;
    vld_d      = vld_shift;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (work_valid) begin
          state_d    = ST_SCAN;
          midstate_d = work_midstate;
          tail_d     = work_tail;
          target_d   = work_target;
          end_d      = work_nonce_end;
          issue_d    = work_nonce_start;
          result_d   = work_nonce_start;
        end
      end
      ST_SCAN: begin
        if (abort_fire) begin
          state_d = ST_IDLE;
          vld_d   = '0;
          done_d  = 1'b1;
        end else begin
          // Counter wraps naturally through 0xFFFFFFFF -> 0.
          issue_d = issue_q + 32'd1;
          if (issue_q == end_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (abort_fire) begin
          state_d = ST_IDLE;
          vld_d   = '0;
          done_d  = 1'b1;
        end else if (vld_shift == '0) begin
          // Last in-flight result has just been compared.
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = '0;
      end
    endcase
  end

  // Scanner state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      midstate_q <= '0;
      tail_q     <= '0;
      target_q   <= '0;
      end_q      <= '0;
      issue_q    <= '0;
      result_q   <= '0;
      vld_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      midstate_q <= midstate_d;
      tail_q     <= tail_d;
      target_q   <= target_d;
      end_q      <= end_d;
      issue_q    <= issue_d;
      result_q   <= result_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
    end
  end

  hit_fifo #(
    .DEPTH (HIT_DEPTH),
    .WIDTH ($bits(nonce_t))
  ) u_hit_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (hit_accept),
    .push_data (result_q),
    .pop       (found_ready),
    .head      (found_nonce),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign work_ready  = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign found_valid = !fifo_empty;
  assign hash0       = midstate_q;
  // Only SCAN presents a nonce; elsewhere data1 idles at zero.
  assign data1       = (state_q == ST_SCAN) ? {DATA1_PAD, issue_q, tail_q} : '0;

`ifdef NONCE_SCANNER_DROP_CNT_EN
  logic        hit_drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign hit_drop = hit && !hit_accept;

  // Saturating drop counter, restarted for each new job.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (handshake) begin
      drop_cnt_d = '0;
    end else if (hit_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  // Without the drop counter the handshake strobe has no other consumer.
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_nonce_scanner.sv
// Self-checking bench for nonce_scanner: a table of jobs with hand-derived
// results, plus directed sequences for FIFO overflow, abort, and reset
// during DRAIN. hash2 comes from a delay-line model of sha256_double that
// returns sp_hash for the nonce sp_nonce and other_hash for every other one.
module tb_nonce_scanner;

  localparam int LAT   = 129;
  localparam int DEPTH = 4;

  localparam logic [255:0] ONES = {256{1'b1}};
  localparam logic [255:0] MID  = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_0f0f0f0ff0f0f0f0;
  localparam logic [95:0]  TAIL = 96'haabbccdd_11223344_55667788;
  localparam logic [383:0] PAD  = {32'h00000280, 320'h0, 32'h80000000};

  logic         clk;
  logic         rst_n;
  logic         work_valid;
  logic         work_ready;
  logic [255:0] work_midstate;
  logic [95:0]  work_tail;
  logic [255:0] work_target;
  logic [31:0]  work_nonce_start;
  logic [31:0]  work_nonce_end;
  logic         abort;
  logic [255:0] hash0;
  logic [511:0] data1;
  logic [255:0] hash2;
  logic         found_valid;
  logic         found_ready;
  logic [31:0]  found_nonce;
  logic         busy;
  logic         done;
`ifdef NONCE_SCANNER_DROP_CNT_EN
  logic [15:0]  drop_cnt;
  logic [15:0]  drop_snap;
`endif

  nonce_scanner #(.PIPE_LAT(LAT), .HIT_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .work_valid       (work_valid),
    .work_ready       (work_ready),
    .work_midstate    (work_midstate),
    .work_tail        (work_tail),
    .work_target      (work_target),
    .work_nonce_start (work_nonce_start),
    .work_nonce_end   (work_nonce_end),
    .abort            (abort),
    .hash0            (hash0),
    .data1            (data1),
    .hash2            (hash2),
    .found_valid      (found_valid),
    .found_ready      (found_ready),
    .found_nonce      (found_nonce),
    .busy             (busy),
    .done             (done)
`ifdef NONCE_SCANNER_DROP_CNT_EN
    ,
    .drop_cnt         (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sha256_double stand-in: the nonce on data1 comes back LAT clocks later.
  logic [31:0]  sp_nonce;
  logic [255:0] sp_hash;
  logic [255:0] other_hash;
  logic [31:0]  pipe_q [LAT];

  always @(posedge clk) begin
    pipe_q[0] <= data1[127:96];
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign hash2 = (pipe_q[LAT-1] == sp_nonce) ? sp_hash : other_hash;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [31:0]  issued_q [$];
  logic [31:0]  got_q [$];
  int           first_issue_t;
  logic [511:0] first_data1;
  logic [255:0] first_hash0;

  // Offer one job, then watch it cycle by cycle (t = cycles after handshake)
  // until done, stop_t, or the budget runs out.
  task automatic run_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt,
                         input logic rdy, input int abort_t, input int stop_t, input int budget,
                         output int done_t);
    issued_q.delete();
    got_q.delete();
    first_issue_t = -1;
    first_data1   = '0;
    first_hash0   = '0;
    done_t        = -1;
    @(negedge clk);
    work_valid       = 1'b1;
    work_nonce_start = s;
    work_nonce_end   = e;
    work_target      = tgt;
    found_ready      = rdy;
    @(negedge clk);
    work_valid = 1'b0;
    for (int t = 1; t <= budget; t++) begin
      abort = (t == abort_t);
`ifdef NONCE_SCANNER_DROP_CNT_EN
      if (t == 1) drop_snap = drop_cnt;
`endif
      if (data1[511:480] == 32'h00000280) begin
        if (first_issue_t < 0) begin
          first_issue_t = t;
          first_data1   = data1;
          first_hash0   = hash0;
        end
        issued_q.push_back(data1[127:96]);
      end
      if (found_valid && found_ready) got_q.push_back(found_nonce);
      if (done) begin
        done_t = t;
        break;
      end
      if (t == stop_t) break;
      @(negedge clk);
    end
    abort = 1'b0;
    $display("job start=%08h end=%08h issued=%0d popped=%0d done_t=%0d",
             s, e, issued_q.size(), got_q.size(), done_t);
  endtask

  typedef struct {
    logic [31:0]  start;
    logic [31:0]  stop;
    logic [255:0] target;
    logic [31:0]  sp;
    logic [255:0] sp_h;
    logic [255:0] oth_h;
    int           exp_n;
    int           exp_hits;
    logic [31:0]  exp_last;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] exp_q [$];

  initial begin
    int          dt;
    logic [31:0] n;
    logic [255:0] h;

    rst_n            = 1'b0;
    work_valid       = 1'b0;
    work_midstate    = MID;
    work_tail        = TAIL;
    work_target      = '0;
    work_nonce_start = '0;
    work_nonce_end   = '0;
    abort            = 1'b0;
    found_ready      = 1'b0;
    sp_nonce         = '0;
    sp_hash          = '0;
    other_hash       = '0;

    //          start         end           target                         sp        sp_hash                        other_hash        n  hits last
    vecs[0] = '{32'h00000010, 32'h00000013, ONES,                          32'h0,    256'h0,                        256'h1234,        4, 4, 32'h00000013};
    vecs[1] = '{32'hFFFFFFFE, 32'h00000001, 256'h0,                        32'h0,    256'h0,                        ONES,             4, 1, 32'h00000001};
    vecs[2] = '{32'h00000055, 32'h00000055, ONES,                          32'h0,    256'h0,                        256'h77,          1, 1, 32'h00000055};
    vecs[3] = '{32'h00000200, 32'h00000202, {8'h00, {248{1'b1}}},          32'h201,  {8'h00, {248{1'b1}}},          {8'h01, 248'h0},  3, 1, 32'h00000202};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 256'h0,                        32'h0,    256'h0,                        256'h1,           1, 0, 32'hFFFFFFFF};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_work_ready", 512'(work_ready), 512'(1'b1));
    chk("rst_busy", 512'(busy), 512'(1'b0));
    chk("rst_done", 512'(done), 512'(1'b0));
    chk("rst_found_valid", 512'(found_valid), 512'(1'b0));
    chk("rst_found_nonce", 512'(found_nonce), 512'(32'h0));
    chk("rst_hash0", 512'(hash0), 512'(256'h0));
    chk("rst_data1", data1, 512'h0);
`ifdef NONCE_SCANNER_DROP_CNT_EN
    chk("rst_drop_cnt", 512'(drop_cnt), 512'(16'h0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven jobs, consumer always ready.
    for (int v = 0; v < 5; v++) begin
      sp_nonce   = vecs[v].sp;
      sp_hash    = vecs[v].sp_h;
      other_hash = vecs[v].oth_h;
      exp_q.delete();
      n = vecs[v].start;
      for (int k = 0; k < vecs[v].exp_n; k++) begin
        h = (n == vecs[v].sp) ? vecs[v].sp_h : vecs[v].oth_h;
        if (h <= vecs[v].target) exp_q.push_back(n);
        n = n + 32'd1;
      end
      run_job(vecs[v].start, vecs[v].stop, vecs[v].target, 1'b1, 0, 0, vecs[v].exp_n + LAT + 20, dt);
      chk_int($sformatf("v%0d_done_t", v), dt, vecs[v].exp_n + LAT + 1);
      chk_int($sformatf("v%0d_first_issue_t", v), first_issue_t, 1);
      chk_int($sformatf("v%0d_issued", v), issued_q.size(), vecs[v].exp_n);
      chk($sformatf("v%0d_first_nonce", v), 512'(issued_q.size() > 0 ? issued_q[0] : 32'hDEADBEEF), 512'(vecs[v].start));
      chk($sformatf("v%0d_last_nonce", v), 512'(issued_q.size() > 0 ? issued_q[issued_q.size()-1] : 32'hDEADBEEF), 512'(vecs[v].exp_last));
      chk($sformatf("v%0d_hash0", v), 512'(first_hash0), 512'(MID));
      chk_int($sformatf("v%0d_hit_count", v), got_q.size(), vecs[v].exp_hits);
      for (int k = 0; k < exp_q.size(); k++)
        chk($sformatf("v%0d_hit%0d", v, k), 512'(k < got_q.size() ? got_q[k] : 32'hDEADBEEF), 512'(exp_q[k]));
      chk($sformatf("v%0d_ready_at_done", v), 512'(work_ready), 512'(1'b1));
      if (v == 2) chk("v2_data1_layout", first_data1, {PAD, 32'h00000055, TAIL});
    end

    // Six hits into a 4-deep FIFO with no consumer: four kept, two dropped.
    sp_nonce   = 32'h0;
    sp_hash    = 256'h0;
    other_hash = 256'h0;
    run_job(32'h20, 32'h25, ONES, 1'b0, 0, 0, 6 + LAT + 20, dt);
    chk_int("ovf_done_t", dt, 6 + LAT + 1);
    chk("ovf_found_valid", 512'(found_valid), 512'(1'b1));
    chk("ovf_head_stable", 512'(found_nonce), 512'(32'h20));
`ifdef NONCE_SCANNER_DROP_CNT_EN
    chk("ovf_drop_cnt", 512'(drop_cnt), 512'(16'd2));
`endif
    got_q.delete();
    found_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (found_valid) got_q.push_back(found_nonce);
      @(negedge clk);
    end
    found_ready = 1'b0;
    chk_int("ovf_popped", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovf_entry%0d", i), 512'(i < got_q.size() ? got_q[i] : 32'hDEADBEEF), 512'(32'h20 + i));

    // Abort while idle does nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_done", 512'(done), 512'(1'b0));
    chk("idle_abort_ready", 512'(work_ready), 512'(1'b1));

    // Leave one pending hit, then abort a long job after ten nonces.
    run_job(32'h77, 32'h77, ONES, 1'b0, 0, 0, 1 + LAT + 20, dt);
    chk_int("pre_done_t", dt, 1 + LAT + 1);
`ifdef NONCE_SCANNER_DROP_CNT_EN
    chk("drop_cnt_cleared", 512'(drop_snap), 512'(16'd0));
`endif
    run_job(32'h100, 32'h1FF, ONES, 1'b0, 10, 0, 300, dt);
    chk_int("abort_done_t", dt, 11);
    chk_int("abort_issued", issued_q.size(), 10);
    repeat (LAT + 10) @(negedge clk);
    chk("abort_idle", 512'(work_ready), 512'(1'b1));
    chk("abort_pending_valid", 512'(found_valid), 512'(1'b1));
    chk("abort_pending_nonce", 512'(found_nonce), 512'(32'h77));
    found_ready = 1'b1;
    @(negedge clk);
    found_ready = 1'b0;
    chk("abort_no_extra_writes", 512'(found_valid), 512'(1'b0));

    // Reset asserted during DRAIN with a hit queued.
    run_job(32'h30, 32'h32, ONES, 1'b0, 0, LAT + 3, LAT + 20, dt);
    chk_int("drain_not_done", dt, -1);
    chk("drain_busy", 512'(busy), 512'(1'b1));
    chk("drain_found_valid", 512'(found_valid), 512'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("arst_work_ready", 512'(work_ready), 512'(1'b1));
    chk("arst_busy", 512'(busy), 512'(1'b0));
    chk("arst_done", 512'(done), 512'(1'b0));
    chk("arst_found_valid", 512'(found_valid), 512'(1'b0));
    chk("arst_found_nonce", 512'(found_nonce), 512'(32'h0));
    chk("arst_hash0", 512'(hash0), 512'(256'h0));
    chk("arst_data1", data1, 512'h0);
`ifdef NONCE_SCANNER_DROP_CNT_EN
    chk("arst_drop_cnt", 512'(drop_cnt), 512'(16'h0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 512'(work_ready), 512'(1'b1));
    chk("post_rst_busy", 512'(busy), 512'(1'b0));
    chk("post_rst_found_valid", 512'(found_valid), 512'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Last-resort guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
